// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_core
//  Purpose  : Multi-cycle RISC-V subset core (add/sub/and/or/mul/addi/lw/sw/
//             beq) with a shared req/ack memory port for fetch and data.
//             Optional bne support is enabled by MULTICYCLE_CORE_BNE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_core #(
  parameter int             XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ack_i,
  output logic [XLEN-1:0] pc_o,
  output logic            retire_o,
  output logic            halt_o
);

  localparam int              ALIGN_BITS = $clog2(XLEN / 8);
  localparam logic [XLEN-1:0] c_PC_STEP  = XLEN'(4);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE
  } op_t;

  state_t          state_q;
  op_t             op_q, op_d;
  logic [XLEN-1:0] pc_q, a_q, b_q, imm_q, alu_q, mdr_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] rf_q [0:31];
  logic            req_q, we_q, retire_q, halt_q;
  logic [XLEN-1:0] addr_q, wdata_q;

  logic            legal_d;
  logic [XLEN-1:0] imm_d, alu_d, rs1_val_d, rs2_val_d, pc_seq_d, br_tgt_d;
  logic            taken_d, misaligned_d;

  // Instruction fields
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  // x0 is hardwired to zero on the read side; writes to it are dropped in WB
  assign rs1_val_d = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val_d = (rs2 == 5'd0) ? '0 : rf_q[rs2];

  // Decode opcode/funct into an operation and its sign-extended immediate
  always_comb begin
    op_d    = OP_ADD;
    legal_d = 1'b0;
    imm_d   = '0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000 && funct3 == 3'b000) begin op_d = OP_ADD; legal_d = 1'b1; end
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin op_d = OP_SUB; legal_d = 1'b1; end
        else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin op_d = OP_AND; legal_d = 1'b1; end
        else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin op_d = OP_OR;  legal_d = 1'b1; end
        else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin op_d = OP_MUL; legal_d = 1'b1; end
      end
      7'b0010011: begin
        imm_d = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        if (funct3 == 3'b000) begin op_d = OP_ADDI; legal_d = 1'b1; end
      end
      7'b0000011: begin
        imm_d = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        if (funct3 == 3'b010) begin op_d = OP_LW; legal_d = 1'b1; end
      end
      7'b0100011: begin
        imm_d = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        if (funct3 == 3'b010) begin op_d = OP_SW; legal_d = 1'b1; end
      end
      7'b1100011: begin
        imm_d = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        if (funct3 == 3'b000) begin op_d = OP_BEQ; legal_d = 1'b1; end
`ifdef MULTICYCLE_CORE_BNE_EN
        else if (funct3 == 3'b001) begin op_d = OP_BNE; legal_d = 1'b1; end
`endif
      end
      default: ;
    endcase
  end

  // ALU, branch decision and address alignment check for the EXEC state
  always_comb begin
    case (op_q)
      OP_ADD:  alu_d = a_q + b_q;
      OP_SUB:  alu_d = a_q - b_q;
      OP_AND:  alu_d = a_q & b_q;
      OP_OR:   alu_d = a_q | b_q;
      OP_MUL:  alu_d = a_q * b_q;
      default: alu_d = a_q + imm_q;
    endcase
    taken_d      = (op_q == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
    pc_seq_d     = pc_q + c_PC_STEP;
    br_tgt_d     = taken_d ? (pc_q + imm_q) : pc_seq_d;
    misaligned_d = (alu_d[ALIGN_BITS-1:0] != '0);
  end

  // Control FSM with registered memory-port and status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      retire_q <= 1'b0;
      halt_q   <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= pc_q;
          end
        end
        S_FETCH: begin
          if (mem_ack_i) begin
            ir_q    <= mem_rdata_i[31:0];
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q   <= rs1_val_d;
          b_q   <= rs2_val_d;
          imm_q <= imm_d;
          op_q  <= op_d;
          if (legal_d) begin
            state_q <= S_EXEC;
          end else begin
            state_q <= S_HALT;
            halt_q  <= 1'b1;
          end
        end
        S_EXEC: begin
          alu_q <= alu_d;
          case (op_q)
            OP_BEQ, OP_BNE: begin
              pc_q     <= br_tgt_d;
              retire_q <= 1'b1;
              state_q  <= S_FETCH;
              req_q    <= 1'b1;
              we_q     <= 1'b0;
              addr_q   <= br_tgt_d;
            end
            OP_LW, OP_SW: begin
              if (misaligned_d) begin
                state_q <= S_HALT;
                halt_q  <= 1'b1;
              end else begin
                state_q <= S_MEM;
                req_q   <= 1'b1;
                we_q    <= (op_q == OP_SW);
                addr_q  <= alu_d;
                wdata_q <= b_q;
              end
            end
            default: state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ack_i) begin
            we_q <= 1'b0;
            if (op_q == OP_SW) begin
              // Store completes here; the next fetch request follows directly
              pc_q     <= pc_seq_d;
              retire_q <= 1'b1;
              state_q  <= S_FETCH;
              req_q    <= 1'b1;
              addr_q   <= pc_seq_d;
            end else begin
              mdr_q   <= mem_rdata_i;
              req_q   <= 1'b0;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          if (rd != 5'd0) rf_q[rd] <= (op_q == OP_LW) ? mdr_q : alu_q;
          pc_q     <= pc_seq_d;
          retire_q <= 1'b1;
          state_q  <= S_FETCH;
          req_q    <= 1'b1;
          we_q     <= 1'b0;
          addr_q   <= pc_seq_d;
        end
        S_HALT: begin
          req_q  <= 1'b0;
          we_q   <= 1'b0;
          halt_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign pc_o        = pc_q;
  assign retire_o    = retire_q;
  assign halt_o      = halt_q;

endmodule
`default_nettype wire
